icache_refill_module: RTL and testbench

- Memory-side responder for instruction-cache misses; the other end of the icache miss/refill interface.
- Accepts a level-held miss request (valid + physical address) and issues one line-aligned burst read on the 64-bit memory bus.
- Assembles 8 beats into a 512-bit line and returns it as a one-cycle refill pulse to the icache.
- Sits between the icache top and the memory/L2 bus port.

---
 rtl/icache_refill_module_pkg.sv | 19 +
 rtl/icache_refill_linebuf_module.sv | 55 +++++
 rtl/icache_refill_module.sv | 179 +++++++++++++++++
 tb/tb_icache_refill_module.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_refill_module_pkg.sv
// Shared widths and FSM encoding for the icache refill engine.
package icache_refill_module_pkg;

  localparam int unsigned PHY_ADDR_WIDTH         = 34;
  localparam int unsigned ICACHE_BEAT_WIDTH      = 64;
  localparam int unsigned ICACHE_LINE_WIDTH      = 512;
  localparam int unsigned ICACHE_BEATS           = ICACHE_LINE_WIDTH / ICACHE_BEAT_WIDTH;
  localparam int unsigned ICACHE_BEAT_CNT_W      = 3;
  localparam int unsigned ICACHE_LINE_OFFS_W     = 6;
  localparam int unsigned ICACHE_LINE_ADDR_WIDTH = PHY_ADDR_WIDTH - ICACHE_LINE_OFFS_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BEAT = 2'd2,
    ST_RESP = 2'd3
  } refill_state_e;

endpackage

// File: rtl/icache_refill_linebuf_module.sv
// One-entry buffer of the last delivered line; lookup, capture and invalidate.
// Only instantiated when ICACHE_REFILL_LINE_BUF_EN is defined.
module icache_refill_linebuf_module
  import icache_refill_module_pkg::*;
#(
  parameter int unsigned LADDR_W    = ICACHE_LINE_ADDR_WIDTH,
  parameter int unsigned LINE_WIDTH = ICACHE_LINE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LADDR_W-1:0]    lookup_addr,
  output logic                  hit_c,
  output logic [LINE_WIDTH-1:0] rd_data,
  input  logic                  cap_vld,
  input  logic [LADDR_W-1:0]    cap_addr,
  input  logic [LINE_WIDTH-1:0] cap_data,
  input  logic                  inv_vld,
  input  logic [LADDR_W-1:0]    inv_addr
);

  logic                  valid_q, valid_d;
  logic [LADDR_W-1:0]    addr_q, addr_d;
  logic [LINE_WIDTH-1:0] data_q, data_d;

  // Invalidate is applied after capture so it wins on a same-cycle match.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (cap_vld) begin
      valid_d = 1'b1;
      addr_d  = cap_addr;
      data_d  = cap_data;
    end
    if (inv_vld && (inv_addr == addr_d)) begin
      valid_d = 1'b0;
    end
  end

  assign hit_c   = valid_q && (lookup_addr == addr_q) && !(inv_vld && (inv_addr == addr_q));
  assign rd_data = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/icache_refill_module.sv
// Memory-side refill engine for icache misses: one line-aligned 8-beat burst per miss,
// line returned as a one-cycle pulse. ICACHE_REFILL_LINE_BUF_EN adds a one-line return buffer.
module icache_refill_module
  import icache_refill_module_pkg::*;
#(
  parameter int unsigned PADDR_WIDTH = PHY_ADDR_WIDTH,
  parameter int unsigned BEAT_WIDTH  = ICACHE_BEAT_WIDTH,
  parameter int unsigned LINE_WIDTH  = ICACHE_LINE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_icache_mem_vld,
  input  logic [PADDR_WIDTH-1:0] i_icache_mem_paddr,
  input  logic                   i_cache_flush,
  input  logic                   i_icache_inv_vld,
  input  logic [PADDR_WIDTH-1:0] i_icache_inv_paddr,
  output logic                   o_bus_req_vld,
  input  logic                   i_bus_req_rdy,
  output logic [PADDR_WIDTH-1:0] o_bus_req_addr,
  input  logic                   i_bus_rsp_vld,
  input  logic [BEAT_WIDTH-1:0]  i_bus_rsp_data,
  input  logic                   i_bus_rsp_err,
  output logic                   o_mem_icache_vld,
  output logic [LINE_WIDTH-1:0]  o_mem_icache_data,
  output logic                   o_mem_icache_err,
  output logic                   o_refill_busy
);

  localparam int unsigned BEATS   = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CNT_W   = $clog2(BEATS);
  localparam int unsigned OFFS_W  = $clog2(LINE_WIDTH / 8);
  localparam int unsigned LADDR_W = PADDR_WIDTH - OFFS_W;
  localparam int unsigned ASM_W   = LINE_WIDTH - BEAT_WIDTH;

  refill_state_e         state_q, state_d;
  logic [LADDR_W-1:0]    line_addr_q, line_addr_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  kill_q, kill_d;
  logic                  err_q, err_d;
  logic [ASM_W-1:0]      asm_q, asm_d;
  logic [LINE_WIDTH-1:0] data_q, data_d;
  logic                  bus_req_vld_q, bus_req_vld_d;
  logic                  busy_q, busy_d;

  logic                  buf_hit_c;
  logic [LINE_WIDTH-1:0] buf_data_c;
  logic                  resp_c;
  logic                  deliver_c;
  logic [LADDR_W-1:0]    miss_line_c;

  assign miss_line_c = i_icache_mem_paddr[PADDR_WIDTH-1:OFFS_W];
  assign resp_c      = (state_q == ST_RESP);
  assign deliver_c   = resp_c && !err_q && !i_cache_flush;

  // Beats 0..BEATS-2 are staged in asm_q; the last beat merges straight into the output line,
  // so o_mem_icache_data only changes when a line is about to be returned.
  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    beat_cnt_d  = beat_cnt_q;
    kill_d      = kill_q;
    err_d       = err_q;
    asm_d       = asm_q;
    data_d      = data_q;
    case (state_q)
      ST_IDLE: begin
        if (i_icache_mem_vld && !i_cache_flush) begin
          line_addr_d = miss_line_c;
          kill_d      = 1'b0;
          err_d       = 1'b0;
          if (buf_hit_c) begin
            state_d = ST_RESP;
            data_d  = buf_data_c;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (i_cache_flush) kill_d = 1'b1;
        if (i_bus_req_rdy) begin
          state_d    = ST_BEAT;
          beat_cnt_d = '0;
        end
      end
      ST_BEAT: begin
        if (i_cache_flush) kill_d = 1'b1;
        if (i_bus_rsp_vld) begin
          for (int b = 0; b < int'(BEATS) - 1; b++) begin
            if (beat_cnt_q == CNT_W'(b)) asm_d[b*BEAT_WIDTH +: BEAT_WIDTH] = i_bus_rsp_data;
          end
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          err_d      = err_q | i_bus_rsp_err;
          if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
            if (kill_q || i_cache_flush) begin
              state_d = ST_IDLE;
              kill_d  = 1'b0;
              err_d   = 1'b0;
            end else begin
              state_d = ST_RESP;
              data_d  = {i_bus_rsp_data, asm_q};
            end
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        kill_d  = 1'b0;
        err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    bus_req_vld_d = (state_d == ST_REQ);
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      line_addr_q   <= '0;
      beat_cnt_q    <= '0;
      kill_q        <= 1'b0;
      err_q         <= 1'b0;
      asm_q         <= '0;
      data_q        <= '0;
      bus_req_vld_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_addr_q   <= line_addr_d;
      beat_cnt_q    <= beat_cnt_d;
      kill_q        <= kill_d;
      err_q         <= err_d;
      asm_q         <= asm_d;
      data_q        <= data_d;
      bus_req_vld_q <= bus_req_vld_d;
      busy_q        <= busy_d;
    end
  end

  assign o_bus_req_vld     = bus_req_vld_q;
  assign o_bus_req_addr    = {line_addr_q, {OFFS_W{1'b0}}};
  assign o_mem_icache_vld  = deliver_c;
  assign o_mem_icache_err  = resp_c && err_q && !i_cache_flush;
  assign o_mem_icache_data = data_q;
  assign o_refill_busy     = busy_q;

`ifdef ICACHE_REFILL_LINE_BUF_EN
  icache_refill_linebuf_module #(
    .LADDR_W    (LADDR_W),
    .LINE_WIDTH (LINE_WIDTH)
  ) u_linebuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_addr (miss_line_c),
    .hit_c       (buf_hit_c),
    .rd_data     (buf_data_c),
    .cap_vld     (deliver_c),
    .cap_addr    (line_addr_q),
    .cap_data    (data_q),
    .inv_vld     (i_icache_inv_vld),
    .inv_addr    (i_icache_inv_paddr[PADDR_WIDTH-1:OFFS_W])
  );

  logic unused_offs_c;
  assign unused_offs_c = ^{i_icache_mem_paddr[OFFS_W-1:0], i_icache_inv_paddr[OFFS_W-1:0]};
`else
  assign buf_hit_c  = 1'b0;
  assign buf_data_c = '0;

  logic unused_inv_c;
  assign unused_inv_c = ^{i_icache_inv_vld, i_icache_inv_paddr, i_icache_mem_paddr[OFFS_W-1:0]};
`endif

  // Beats may only arrive while a burst is outstanding.
  rsp_only_in_beat_a : assert property (@(posedge clk) disable iff (!rst_n)
    i_bus_rsp_vld |-> (state_q == ST_BEAT));

endmodule

// File: tb/tb_icache_refill_module.sv
// Directed bench for icache_refill_module; line-buffer scenarios run when ICACHE_REFILL_LINE_BUF_EN is defined.
module tb_icache_refill_module;

  logic         clk;
  logic         rst_n;
  logic         i_icache_mem_vld;
  logic [33:0]  i_icache_mem_paddr;
  logic         i_cache_flush;
  logic         i_icache_inv_vld;
  logic [33:0]  i_icache_inv_paddr;
  logic         o_bus_req_vld;
  logic         i_bus_req_rdy;
  logic [33:0]  o_bus_req_addr;
  logic         i_bus_rsp_vld;
  logic [63:0]  i_bus_rsp_data;
  logic         i_bus_rsp_err;
  logic         o_mem_icache_vld;
  logic [511:0] o_mem_icache_data;
  logic         o_mem_icache_err;
  logic         o_refill_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int vld_pulses = 0;
  int err_pulses = 0;
  int req_rises  = 0;
  logic req_prev = 1'b0;

  localparam logic [63:0] BASE_A = 64'h1111_0000_0000_0000;
  localparam logic [63:0] BASE_B = 64'hB0B0_0000_0000_0000;
  localparam logic [63:0] BASE_C = 64'hC0C0_0000_0000_0000;
  localparam logic [63:0] BASE_D = 64'hD0D0_0000_0000_0000;
  localparam logic [63:0] BASE_E = 64'hE0E0_0000_0000_0000;
  localparam logic [63:0] BASE_F = 64'hF0F0_0000_0000_0000;
  localparam logic [63:0] BASE_G = 64'h9090_0000_0000_0000;

  icache_refill_module dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_icache_mem_vld   (i_icache_mem_vld),
    .i_icache_mem_paddr (i_icache_mem_paddr),
    .i_cache_flush      (i_cache_flush),
    .i_icache_inv_vld   (i_icache_inv_vld),
    .i_icache_inv_paddr (i_icache_inv_paddr),
    .o_bus_req_vld      (o_bus_req_vld),
    .i_bus_req_rdy      (i_bus_req_rdy),
    .o_bus_req_addr     (o_bus_req_addr),
    .i_bus_rsp_vld      (i_bus_rsp_vld),
    .i_bus_rsp_data     (i_bus_rsp_data),
    .i_bus_rsp_err      (i_bus_rsp_err),
    .o_mem_icache_vld   (o_mem_icache_vld),
    .o_mem_icache_data  (o_mem_icache_data),
    .o_mem_icache_err   (o_mem_icache_err),
    .o_refill_busy      (o_refill_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse and request-edge counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_mem_icache_vld === 1'b1) vld_pulses++;
    if (o_mem_icache_err === 1'b1) err_pulses++;
    if (o_bus_req_vld === 1'b1 && req_prev !== 1'b1) req_rises++;
    req_prev = o_bus_req_vld;
  end

  function automatic logic [511:0] exp_line(input logic [63:0] base);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[64*k +: 64] = base | 64'(k);
    return l;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic miss(input logic [33:0] pa);
    i_icache_mem_vld   = 1'b1;
    i_icache_mem_paddr = pa;
    cyc();
    i_icache_mem_vld   = 1'b0;
  endtask

  // Called in the first REQ cycle: rdy for one cycle, then 8 beats (optional error/flush/gap beat).
  task automatic serve(input logic [63:0] base, input int err_beat, input int flush_beat, input int gap_beat);
    i_bus_req_rdy = 1'b1;
    cyc();
    i_bus_req_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == gap_beat) begin
        i_bus_rsp_vld = 1'b0;
        cyc();
      end
      i_bus_rsp_vld  = 1'b1;
      i_bus_rsp_data = base | 64'(k);
      i_bus_rsp_err  = (k == err_beat);
      i_cache_flush  = (k == flush_beat);
      cyc();
    end
    i_bus_rsp_vld  = 1'b0;
    i_bus_rsp_err  = 1'b0;
    i_cache_flush  = 1'b0;
    i_bus_rsp_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    n_checks++; if (o_bus_req_vld !== 1'b0) begin n_fail++; $display("FAIL reset_req_vld got=%b exp=0", o_bus_req_vld); end
    n_checks++; if (o_bus_req_addr !== 34'h0) begin n_fail++; $display("FAIL reset_req_addr got=%h exp=0", o_bus_req_addr); end
    n_checks++; if (o_mem_icache_vld !== 1'b0) begin n_fail++; $display("FAIL reset_mem_vld got=%b exp=0", o_mem_icache_vld); end
    n_checks++; if (o_mem_icache_err !== 1'b0) begin n_fail++; $display("FAIL reset_mem_err got=%b exp=0", o_mem_icache_err); end
    n_checks++; if (o_mem_icache_data !== 512'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", o_mem_icache_data); end
    n_checks++; if (o_refill_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", o_refill_busy); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    int v0;
    v0 = vld_pulses;
    miss(34'h0_1234_5678);
    n_checks++; if (o_bus_req_vld !== 1'b1) begin n_fail++; $display("FAIL basic_req_vld got=%b exp=1", o_bus_req_vld); end
    n_checks++; if (o_bus_req_addr !== 34'h0_1234_5640) begin n_fail++; $display("FAIL basic_req_addr got=%h exp=012345640", o_bus_req_addr); end
    n_checks++; if (o_refill_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%b exp=1", o_refill_busy); end
    serve(BASE_A, -1, -1, -1);
    n_checks++; if (o_mem_icache_vld !== 1'b1) begin n_fail++; $display("FAIL basic_resp_vld got=%b exp=1", o_mem_icache_vld); end
    n_checks++; if (o_mem_icache_err !== 1'b0) begin n_fail++; $display("FAIL basic_resp_err got=%b exp=0", o_mem_icache_err); end
    n_checks++; if (o_mem_icache_data[63:0] !== 64'h1111_0000_0000_0000) begin n_fail++; $display("FAIL basic_beat0 got=%h exp=1111000000000000", o_mem_icache_data[63:0]); end
    n_checks++; if (o_mem_icache_data[511:448] !== 64'h1111_0000_0000_0007) begin n_fail++; $display("FAIL basic_beat7 got=%h exp=1111000000000007", o_mem_icache_data[511:448]); end
    n_checks++; if (o_mem_icache_data !== exp_line(BASE_A)) begin n_fail++; $display("FAIL basic_line got=%h exp=%h", o_mem_icache_data, exp_line(BASE_A)); end
    cyc();
    n_checks++; if (o_mem_icache_vld !== 1'b0) begin n_fail++; $display("FAIL basic_vld_drop got=%b exp=0", o_mem_icache_vld); end
    n_checks++; if (o_refill_busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle got=%b exp=0", o_refill_busy); end
    n_checks++; if (o_mem_icache_data !== exp_line(BASE_A)) begin n_fail++; $display("FAIL basic_data_hold got=%h exp=%h", o_mem_icache_data, exp_line(BASE_A)); end
    n_checks++; if (vld_pulses - v0 !== 1) begin n_fail++; $display("FAIL basic_pulse_count got=%0d exp=1", vld_pulses - v0); end
  endtask

  task automatic test_rdy_stall();
    miss(34'h3_FFFF_FFC7);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({o_bus_req_vld, o_bus_req_addr} !== {1'b1, 34'h3_FFFF_FFC0}) begin
        n_fail++; $display("FAIL stall_req_stable cyc=%0d got=%b/%h exp=1/3ffffffc0", i + 1, o_bus_req_vld, o_bus_req_addr);
      end
      if (i < 5) cyc();
    end
    serve(BASE_B, -1, -1, -1);
    n_checks++; if (o_mem_icache_vld !== 1'b1) begin n_fail++; $display("FAIL stall_resp_vld got=%b exp=1", o_mem_icache_vld); end
    n_checks++; if (o_mem_icache_data !== exp_line(BASE_B)) begin n_fail++; $display("FAIL stall_line got=%h exp=%h", o_mem_icache_data, exp_line(BASE_B)); end
    cyc();
  endtask

  task automatic test_flush_kill();
    int v0, e0;
    v0 = vld_pulses;
    e0 = err_pulses;
    miss(34'h1_0000_0010);
    serve(BASE_C, -1, 3, -1);
    n_checks++; if (o_refill_busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after_beat7 got=%b exp=0", o_refill_busy); end
    n_checks++; if (o_mem_icache_vld !== 1'b0) begin n_fail++; $display("FAIL flush_no_vld got=%b exp=0", o_mem_icache_vld); end
    n_checks++; if (vld_pulses - v0 !== 0 || err_pulses - e0 !== 0) begin n_fail++; $display("FAIL flush_no_pulse got=%0d/%0d exp=0/0", vld_pulses - v0, err_pulses - e0); end
    n_checks++; if (o_mem_icache_data !== exp_line(BASE_B)) begin n_fail++; $display("FAIL flush_data_hold got=%h exp=%h", o_mem_icache_data, exp_line(BASE_B)); end
    miss(34'h1_0000_0040);
    n_checks++; if ({o_bus_req_vld, o_bus_req_addr} !== {1'b1, 34'h1_0000_0040}) begin n_fail++; $display("FAIL flush_next_miss got=%b/%h exp=1/100000040", o_bus_req_vld, o_bus_req_addr); end
    serve(BASE_D, -1, -1, -1);
    n_checks++; if (o_mem_icache_vld !== 1'b1) begin n_fail++; $display("FAIL flush_next_resp got=%b exp=1", o_mem_icache_vld); end
    n_checks++; if (o_mem_icache_data !== exp_line(BASE_D)) begin n_fail++; $display("FAIL flush_next_line got=%h exp=%h", o_mem_icache_data, exp_line(BASE_D)); end
    cyc();
  endtask

  task automatic test_err();
    int v0, e0;
    v0 = vld_pulses;
    e0 = err_pulses;
    i_icache_mem_vld   = 1'b1;
    i_icache_mem_paddr = 34'h0_0BAD_00A0;
    i_cache_flush      = 1'b1;
    cyc();
    i_cache_flush = 1'b0;
    n_checks++; if ({o_bus_req_vld, o_refill_busy} !== 2'b00) begin n_fail++; $display("FAIL err_flush_wins got=%b%b exp=00", o_bus_req_vld, o_refill_busy); end
    cyc();
    i_icache_mem_vld = 1'b0;
    n_checks++; if ({o_bus_req_vld, o_bus_req_addr} !== {1'b1, 34'h0_0BAD_0080}) begin n_fail++; $display("FAIL err_req got=%b/%h exp=1/00bad0080", o_bus_req_vld, o_bus_req_addr); end
    serve(BASE_E, 5, -1, 2);
    n_checks++; if (o_mem_icache_err !== 1'b1) begin n_fail++; $display("FAIL err_resp_err got=%b exp=1", o_mem_icache_err); end
    n_checks++; if (o_mem_icache_vld !== 1'b0) begin n_fail++; $display("FAIL err_resp_vld got=%b exp=0", o_mem_icache_vld); end
    cyc();
    n_checks++; if ({o_mem_icache_err, o_refill_busy} !== 2'b00) begin n_fail++; $display("FAIL err_clear got=%b%b exp=00", o_mem_icache_err, o_refill_busy); end
    n_checks++; if (err_pulses - e0 !== 1 || vld_pulses - v0 !== 0) begin n_fail++; $display("FAIL err_pulse_count got=%0d/%0d exp=1/0", err_pulses - e0, vld_pulses - v0); end
  endtask

  task automatic test_back_to_back();
    int r0, v0;
    r0 = req_rises;
    v0 = vld_pulses;
    i_icache_mem_vld   = 1'b1;
    i_icache_mem_paddr = 34'h2_ABCD_E0C4;
    cyc();
    n_checks++; if ({o_bus_req_vld, o_bus_req_addr} !== {1'b1, 34'h2_ABCD_E0C0}) begin n_fail++; $display("FAIL b2b_req got=%b/%h exp=1/2abcde0c0", o_bus_req_vld, o_bus_req_addr); end
    serve(BASE_F, -1, -1, -1);
    n_checks++; if ({o_mem_icache_vld, o_bus_req_vld} !== 2'b10) begin n_fail++; $display("FAIL b2b_resp got=%b%b exp=10", o_mem_icache_vld, o_bus_req_vld); end
    cyc();
    n_checks++; if ({o_refill_busy, o_bus_req_vld} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle_gap got=%b%b exp=00", o_refill_busy, o_bus_req_vld); end
    cyc();
    i_icache_mem_vld = 1'b0;
`ifdef ICACHE_REFILL_LINE_BUF_EN
    n_checks++; if ({o_mem_icache_vld, o_bus_req_vld} !== 2'b10) begin n_fail++; $display("FAIL b2b_buf_hit got=%b%b exp=10", o_mem_icache_vld, o_bus_req_vld); end
    n_checks++; if (o_mem_icache_data !== exp_line(BASE_F)) begin n_fail++; $display("FAIL b2b_buf_line got=%h exp=%h", o_mem_icache_data, exp_line(BASE_F)); end
    cyc();
    n_checks++; if (req_rises - r0 !== 1 || vld_pulses - v0 !== 2) begin n_fail++; $display("FAIL b2b_counts got=%0d/%0d exp=1/2", req_rises - r0, vld_pulses - v0); end
`else
    n_checks++; if (o_bus_req_vld !== 1'b1) begin n_fail++; $display("FAIL b2b_second_req got=%b exp=1", o_bus_req_vld); end
    serve(BASE_F, -1, -1, -1);
    n_checks++; if (o_mem_icache_vld !== 1'b1) begin n_fail++; $display("FAIL b2b_second_resp got=%b exp=1", o_mem_icache_vld); end
    cyc();
    cyc();
    n_checks++; if (req_rises - r0 !== 2 || vld_pulses - v0 !== 2) begin n_fail++; $display("FAIL b2b_counts got=%0d/%0d exp=2/2", req_rises - r0, vld_pulses - v0); end
`endif
  endtask

`ifdef ICACHE_REFILL_LINE_BUF_EN
  task automatic test_linebuf();
    miss(34'h2_ABCD_E0F8);
    n_checks++; if ({o_mem_icache_vld, o_bus_req_vld} !== 2'b10) begin n_fail++; $display("FAIL lb_hit got=%b%b exp=10", o_mem_icache_vld, o_bus_req_vld); end
    n_checks++; if (o_mem_icache_data !== exp_line(BASE_F)) begin n_fail++; $display("FAIL lb_hit_line got=%h exp=%h", o_mem_icache_data, exp_line(BASE_F)); end
    cyc();
    n_checks++; if (o_refill_busy !== 1'b0) begin n_fail++; $display("FAIL lb_hit_idle got=%b exp=0", o_refill_busy); end
    i_icache_inv_vld   = 1'b1;
    i_icache_inv_paddr = 34'h2_ABCD_E0C8;
    cyc();
    i_icache_inv_vld = 1'b0;
    miss(34'h2_ABCD_E0F8);
    n_checks++; if ({o_mem_icache_vld, o_bus_req_vld} !== 2'b01) begin n_fail++; $display("FAIL lb_after_inv got=%b%b exp=01", o_mem_icache_vld, o_bus_req_vld); end
    serve(BASE_G, -1, -1, -1);
    n_checks++; if (o_mem_icache_data !== exp_line(BASE_G)) begin n_fail++; $display("FAIL lb_refetch_line got=%h exp=%h", o_mem_icache_data, exp_line(BASE_G)); end
    cyc();
    i_icache_inv_vld   = 1'b1;
    i_icache_inv_paddr = 34'h2_ABCD_E0C0;
    miss(34'h2_ABCD_E0C4);
    i_icache_inv_vld = 1'b0;
    n_checks++; if ({o_mem_icache_vld, o_bus_req_vld} !== 2'b01) begin n_fail++; $display("FAIL lb_same_cycle_inv got=%b%b exp=01", o_mem_icache_vld, o_bus_req_vld); end
    serve(BASE_A, -1, -1, -1);
    cyc();
  endtask
`endif

  initial begin
    rst_n              = 1'b0;
    i_icache_mem_vld   = 1'b0;
    i_icache_mem_paddr = '0;
    i_cache_flush      = 1'b0;
    i_icache_inv_vld   = 1'b0;
    i_icache_inv_paddr = '0;
    i_bus_req_rdy      = 1'b0;
    i_bus_rsp_vld      = 1'b0;
    i_bus_rsp_data     = '0;
    i_bus_rsp_err      = 1'b0;
    test_reset();
    test_basic();
    test_rdy_stall();
    test_flush_kill();
    test_err();
    test_back_to_back();
`ifdef ICACHE_REFILL_LINE_BUF_EN
    test_linebuf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
